// File: rtl/isp_loader_pkg.sv
// isp_loader_pkg: shared definitions for the ISP frame loader.
//   - state_t      : loader FSM encoding (3 bits)
//   - ADDR_BYTES / COUNT_BYTES / WORD_BYTES : frame field lengths in bytes
//   - DEFAULT_SYNC_BYTE : frame header byte
//   - xor_fold     : running checksum step used when ISP_LOADER_CHECKSUM_EN is defined
package isp_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHECK = 3'd5,
    ST_START = 3'd6
  } state_t;

  localparam int ADDR_BYTES  = 3;
  localparam int COUNT_BYTES = 2;
  localparam int WORD_BYTES  = 4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // One step of the frame checksum: XOR of every byte after the sync byte.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/isp_byte_assembler.sv
// isp_byte_assembler: little-endian byte-to-word shift register shared by the
// ADDR, COUNT and DATA fields of an ISP frame.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   clear          : drop any partially assembled field
//   load           : data_in is a byte of the current field this cycle
//   data_in[7:0]   : incoming byte (first byte of a field lands in bits [7:0])
//   length[2:0]    : number of bytes in the current field (1..4)
//   word[31:0]     : assembled value including data_in in its lane
//   full           : this load completes the field; word is then the full value
module isp_byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data_in,
  input  logic [2:0]  length,
  output logic [31:0] word,
  output logic        full
);

  logic [31:0] acc_r;
  logic [2:0]  index_r;

  // Place the incoming byte into the lane selected by the byte index.
  always_comb begin
    word = acc_r;
    case (index_r)
      3'd0:    word[7:0]   = data_in;
      3'd1:    word[15:8]  = data_in;
      3'd2:    word[23:16] = data_in;
      3'd3:    word[31:24] = data_in;
      default: word        = acc_r;
    endcase
  end

  assign full = load && (index_r == (length - 3'd1));

  // Byte index and partial-word register; a completed field restarts at lane 0
  // so the next field can begin on the following byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r   <= 32'd0;
      index_r <= 3'd0;
    end else if (clear || full) begin
      acc_r   <= 32'd0;
      index_r <= 3'd0;
    end else if (load) begin
      acc_r   <= word;
      index_r <= index_r + 3'd1;
    end else begin
      acc_r   <= acc_r;
      index_r <= index_r;
    end
  end

endmodule

// File: rtl/isp_loader.sv
// isp_loader: ISP front end that turns a framed byte stream into 32-bit word
// writes into core instruction memory, then pulses start with the load address.
// Frame: SYNC, ADDR[3] (LE, upper 4 bits ignored), COUNT[2] (LE, words),
//        COUNT*4 data bytes (LE words), and with ISP_LOADER_CHECKSUM_EN defined
//        one checksum byte (XOR of every byte after SYNC).
// Optional feature macro: ISP_LOADER_CHECKSUM_EN (adds the CHECK state).
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   rx_data, rx_valid : incoming byte stream
//   rx_ready          : byte accepted when rx_valid && rx_ready
//   isp_address/isp_data/isp_write : word write port into the core
//   core_stall        : holds the core while a frame is loading
//   start, prog_address : one-cycle start pulse and start PC (held afterwards)
//   busy              : frame in progress
//   error             : sticky timeout/checksum error, cleared by next SYNC
module isp_loader import isp_loader_pkg::*; #(
  parameter int         ADDRESS_BITS   = 20,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    isp_write,
  output logic                    core_stall,
  output logic                    start,
  output logic [ADDRESS_BITS-1:0] prog_address,
  output logic                    busy,
  output logic                    error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef ISP_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = ST_CHECK;
`else
  localparam state_t POST_DATA = ST_START;
`endif

  state_t                  state_r, state_next;
  logic [15:0]             count_r, count_next;
  logic [TW-1:0]           idle_cnt_r, idle_next;
  logic [ADDRESS_BITS-1:0] address_next, prog_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic                    stall_next, error_next, write_next, start_next;
  logic                    accept, counting;
  logic                    asm_load, asm_clear, asm_full;
  logic [2:0]              asm_length;
  logic [31:0]             asm_word;

`ifdef ISP_LOADER_CHECKSUM_EN
  logic [7:0]              xor_r;
`endif

  assign accept = rx_valid && rx_ready;

  isp_byte_assembler u_asm (
    .clock   (clock),
    .reset   (reset),
    .clear   (asm_clear),
    .load    (asm_load),
    .data_in (rx_data),
    .length  (asm_length),
    .word    (asm_word),
    .full    (asm_full)
  );

  // Next-state and next-output decode for the frame FSM, including inactivity timeout.
  always_comb begin
    state_next   = state_r;
    address_next = isp_address;
    data_next    = isp_data;
    prog_next    = prog_address;
    count_next   = count_r;
    idle_next    = idle_cnt_r;
    stall_next   = core_stall;
    error_next   = error;
    write_next   = 1'b0;
    start_next   = 1'b0;
    asm_load     = 1'b0;
    asm_clear    = 1'b0;
    asm_length   = 3'(WORD_BYTES);
    counting     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        asm_clear = 1'b1;
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_next = ST_ADDR;
          stall_next = 1'b1;
          error_next = 1'b0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ADDR: begin
        counting   = 1'b1;
        asm_length = 3'(ADDR_BYTES);
        asm_load   = accept;
        if (asm_full) begin
          address_next = asm_word[ADDRESS_BITS-1:0];
          prog_next    = asm_word[ADDRESS_BITS-1:0];
          state_next   = ST_COUNT;
        end else begin
          state_next = ST_ADDR;
        end
      end
      ST_COUNT: begin
        counting   = 1'b1;
        asm_length = 3'(COUNT_BYTES);
        asm_load   = accept;
        if (asm_full) begin
          count_next = asm_word[15:0];
          if (asm_word[15:0] == 16'd0) begin
            state_next = POST_DATA;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_COUNT;
        end
      end
      ST_DATA: begin
        counting   = 1'b1;
        asm_length = 3'(WORD_BYTES);
        asm_load   = accept;
        if (asm_full) begin
          data_next  = asm_word[DATA_WIDTH-1:0];
          write_next = 1'b1;
          state_next = ST_WRITE;
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_WRITE: begin
        // The strobe cycle is over: advance to the next word slot.
        address_next = isp_address + ADDRESS_BITS'(1);
        count_next   = count_r - 16'd1;
        if (count_r == 16'd1) begin
          state_next = POST_DATA;
        end else begin
          state_next = ST_DATA;
        end
      end
`ifdef ISP_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        counting = 1'b1;
        if (accept) begin
          if (rx_data == xor_r) begin
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
            error_next = 1'b1;
            stall_next = 1'b0;
          end
        end else begin
          state_next = ST_CHECK;
        end
      end
`endif
      ST_START: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Inactivity timeout: only byte-waiting states count; WRITE/START hold the count.
    if (counting) begin
      if (accept) begin
        idle_next = '0;
      end else if (idle_cnt_r == IDLE_LAST) begin
        idle_next  = '0;
        state_next = ST_IDLE;
        error_next = 1'b1;
        stall_next = 1'b0;
      end else begin
        idle_next = idle_cnt_r + TW'(1);
      end
    end else if (state_r == ST_IDLE) begin
      idle_next = '0;
    end else begin
      idle_next = idle_cnt_r;
    end

    // The core is released in the same cycle it is told to start.
    if (state_next == ST_START) begin
      start_next = 1'b1;
      stall_next = 1'b0;
    end else begin
      start_next = 1'b0;
    end
  end

  // State and registered outputs; rx_ready/busy are decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      count_r      <= 16'd0;
      idle_cnt_r   <= '0;
      rx_ready     <= 1'b1;
      isp_address  <= '0;
      isp_data     <= '0;
      isp_write    <= 1'b0;
      core_stall   <= 1'b0;
      start        <= 1'b0;
      prog_address <= '0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_r      <= state_next;
      count_r      <= count_next;
      idle_cnt_r   <= idle_next;
      rx_ready     <= (state_next != ST_WRITE) && (state_next != ST_START);
      isp_address  <= address_next;
      isp_data     <= data_next;
      isp_write    <= write_next;
      core_stall   <= stall_next;
      start        <= start_next;
      prog_address <= prog_next;
      busy         <= (state_next != ST_IDLE);
      error        <= error_next;
    end
  end

`ifdef ISP_LOADER_CHECKSUM_EN
  // Running XOR of every field byte; restarts while waiting for the next sync.
  always_ff @(posedge clock) begin
    if (reset) begin
      xor_r <= 8'd0;
    end else if (state_r == ST_IDLE) begin
      xor_r <= 8'd0;
    end else if (asm_load) begin
      xor_r <= xor_fold(xor_r, rx_data);
    end else begin
      xor_r <= xor_r;
    end
  end
`endif

endmodule

// File: tb/tb_isp_loader.sv
// tb_isp_loader: directed self-checking bench for isp_loader.
module tb_isp_loader;

  localparam int TO = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [19:0] isp_address;
  logic [31:0] isp_data;
  logic        isp_write;
  logic        core_stall;
  logic        start;
  logic [19:0] prog_address;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  isp_loader #(
    .ADDRESS_BITS   (20),
    .DATA_WIDTH     (32),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .isp_address  (isp_address),
    .isp_data     (isp_data),
    .isp_write    (isp_write),
    .core_stall   (core_stall),
    .start        (start),
    .prog_address (prog_address),
    .busy         (busy),
    .error        (error)
  );

  // Observed writes and start pulses
  logic [19:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          start_cnt = 0;
  logic [19:0] start_pc = 20'h0;
  int          stall_bad = 0;
  int          both_cnt = 0;

  always @(negedge clock) begin
    if (isp_write) begin
      wr_addr_q.push_back(isp_address);
      wr_data_q.push_back(isp_data);
      if (!core_stall) stall_bad <= stall_bad + 1;
    end
    if (start) begin
      start_cnt <= start_cnt + 1;
      start_pc  <= prog_address;
      if (core_stall) stall_bad <= stall_bad + 1;
    end
    if (isp_write && start) both_cnt <= both_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_byte: rx_ready actual=%b required=1", rx_ready);
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  // Frame body after SYNC; appends the XOR byte (optionally corrupted) when enabled.
  task automatic send_body(input logic [23:0] a, input logic [15:0] cnt,
                           input logic [31:0] w0, input logic [31:0] w1, input logic bad_ck);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    x = 8'h00;
    for (int i = 0; i < 3; i++) begin b = a[8*i +: 8]; send_byte(b); x = x ^ b; end
    for (int i = 0; i < 2; i++) begin b = cnt[8*i +: 8]; send_byte(b); x = x ^ b; end
    for (int k = 0; k < int'(cnt); k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) begin b = w[8*i +: 8]; send_byte(b); x = x ^ b; end
    end
    b = bad_ck ? ~x : x;
`ifdef ISP_LOADER_CHECKSUM_EN
    send_byte(b);
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cycles(3);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready actual=%b required=1", rx_ready); end
    checks++; if (isp_write !== 1'b0) begin errors++; $display("FAIL reset_isp_write actual=%b required=0", isp_write); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start actual=%b required=0", start); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_core_stall actual=%b required=0", core_stall); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error actual=%b required=0", error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (isp_address !== 20'h0) begin errors++; $display("FAIL reset_isp_address actual=%h required=0", isp_address); end
    checks++; if (isp_data !== 32'h0) begin errors++; $display("FAIL reset_isp_data actual=%h required=0", isp_data); end
    checks++; if (prog_address !== 20'h0) begin errors++; $display("FAIL reset_prog_address actual=%h required=0", prog_address); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_ignore;
    int bw;
    bw = wr_addr_q.size();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    wait_cycles(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy actual=%b required=0", busy); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL ignore_stall actual=%b required=0", core_stall); end
    checks++; if (wr_addr_q.size() !== bw) begin errors++; $display("FAIL ignore_writes actual=%0d required=%0d", wr_addr_q.size(), bw); end
  endtask

  task automatic test_frame;
    int bw, bs;
    bw = wr_addr_q.size();
    bs = start_cnt;
    send_byte(8'hA5);
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL frame_stall_after_sync actual=%b required=1", core_stall); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy actual=%b required=1", busy); end
    send_body(24'h000100, 16'd2, 32'h00000013, 32'h12345678, 1'b0);
    wait_cycles(6);
    checks++; if (wr_addr_q.size() !== bw + 2) begin errors++; $display("FAIL frame_write_count actual=%0d required=%0d", wr_addr_q.size() - bw, 2); end
    else begin
      checks++; if (wr_addr_q[bw] !== 20'h00100) begin errors++; $display("FAIL frame_addr0 actual=%h required=00100", wr_addr_q[bw]); end
      checks++; if (wr_data_q[bw] !== 32'h00000013) begin errors++; $display("FAIL frame_data0 actual=%h required=00000013", wr_data_q[bw]); end
      checks++; if (wr_addr_q[bw+1] !== 20'h00101) begin errors++; $display("FAIL frame_addr1 actual=%h required=00101", wr_addr_q[bw+1]); end
      checks++; if (wr_data_q[bw+1] !== 32'h12345678) begin errors++; $display("FAIL frame_data1 actual=%h required=12345678", wr_data_q[bw+1]); end
    end
    checks++; if (start_cnt !== bs + 1) begin errors++; $display("FAIL frame_start_count actual=%0d required=1", start_cnt - bs); end
    checks++; if (start_pc !== 20'h00100) begin errors++; $display("FAIL frame_start_pc actual=%h required=00100", start_pc); end
    checks++; if (prog_address !== 20'h00100) begin errors++; $display("FAIL frame_prog_held actual=%h required=00100", prog_address); end
    checks++; if (core_stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL frame_release actual=%b%b required=00", core_stall, busy); end
  endtask

  task automatic test_count_zero;
    int bw, bs;
    bw = wr_addr_q.size();
    bs = start_cnt;
    send_byte(8'hA5);
    send_body(24'h001234, 16'd0, 32'h0, 32'h0, 1'b0);
    wait_cycles(5);
    checks++; if (wr_addr_q.size() !== bw) begin errors++; $display("FAIL count0_writes actual=%0d required=0", wr_addr_q.size() - bw); end
    checks++; if (start_cnt !== bs + 1) begin errors++; $display("FAIL count0_start_count actual=%0d required=1", start_cnt - bs); end
    checks++; if (start_pc !== 20'h01234) begin errors++; $display("FAIL count0_start_pc actual=%h required=01234", start_pc); end
  endtask

  task automatic test_timeout;
    int bw, bs;
    bw = wr_addr_q.size();
    bs = start_cnt;
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56);
    wait_cycles(TO - 1);
    checks++; if (error !== 1'b0 || core_stall !== 1'b1) begin errors++; $display("FAIL timeout_early actual=%b%b required=01", error, core_stall); end
    wait_cycles(1);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error actual=%b required=1", error); end
    checks++; if (core_stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_release actual=%b%b required=00", core_stall, busy); end
    wait_cycles(4);
    checks++; if (start_cnt !== bs || wr_addr_q.size() !== bw) begin errors++; $display("FAIL timeout_no_activity actual=%0d/%0d required=0/0", start_cnt - bs, wr_addr_q.size() - bw); end
    send_byte(8'hA5);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_sync_clears actual=%b required=0", error); end
    send_body(24'h000300, 16'd0, 32'h0, 32'h0, 1'b0);
    wait_cycles(5);
    checks++; if (start_cnt !== bs + 1) begin errors++; $display("FAIL timeout_recover_start actual=%0d required=1", start_cnt - bs); end
  endtask

  task automatic test_wrap;
    int bw;
    bw = wr_addr_q.size();
    send_byte(8'hA5);
    // Upper address nibble set to show it is ignored; data word contains the sync byte.
    send_body(24'hFFFFFF, 16'd2, 32'hDEADBEEF, 32'h000000A5, 1'b0);
    wait_cycles(6);
    checks++; if (wr_addr_q.size() !== bw + 2) begin errors++; $display("FAIL wrap_write_count actual=%0d required=2", wr_addr_q.size() - bw); end
    else begin
      checks++; if (wr_addr_q[bw] !== 20'hFFFFF) begin errors++; $display("FAIL wrap_addr0 actual=%h required=fffff", wr_addr_q[bw]); end
      checks++; if (wr_addr_q[bw+1] !== 20'h00000) begin errors++; $display("FAIL wrap_addr1 actual=%h required=00000", wr_addr_q[bw+1]); end
      checks++; if (wr_data_q[bw+1] !== 32'h000000A5) begin errors++; $display("FAIL wrap_sync_as_data actual=%h required=000000a5", wr_data_q[bw+1]); end
    end
    checks++; if (prog_address !== 20'hFFFFF) begin errors++; $display("FAIL wrap_prog actual=%h required=fffff", prog_address); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wrap_error actual=%b required=0", error); end
  endtask

`ifdef ISP_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad;
    int bw, bs;
    bw = wr_addr_q.size();
    bs = start_cnt;
    send_byte(8'hA5);
    send_body(24'h000200, 16'd1, 32'hCAFEF00D, 32'h0, 1'b1);
    wait_cycles(4);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL cksum_error actual=%b required=1", error); end
    checks++; if (start_cnt !== bs) begin errors++; $display("FAIL cksum_no_start actual=%0d required=0", start_cnt - bs); end
    checks++; if (wr_addr_q.size() !== bw + 1) begin errors++; $display("FAIL cksum_write_kept actual=%0d required=1", wr_addr_q.size() - bw); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL cksum_stall actual=%b required=0", core_stall); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [58:0] got;
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    got = {rx_ready, isp_write, start, core_stall, error, busy, isp_address, isp_data[12:0], prog_address};
    checks++; if (got !== {1'b1, 5'b00000, 20'h0, 13'h0, 20'h0} || isp_data !== 32'h0) begin
      errors++; $display("FAIL reset_mid actual=%h required=%h", got, {1'b1, 5'b00000, 20'h0, 13'h0, 20'h0});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_exclusive;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL write_start_overlap actual=%0d required=0", both_cnt); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_timing actual=%0d required=0", stall_bad); end
  endtask

  initial begin
    test_reset();
    test_ignore();
    test_frame();
    test_count_zero();
    test_timeout();
    test_wrap();
`ifdef ISP_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_reset_mid();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
